// File: rtl/tron_pkg.sv
// Shared types and constants for the N-player Tron collision arbiter.
package tron_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRead,
        StCapture,
        StCheck,
        StWrite,
        StResult
    } state_e;

    localparam logic [1:0] RES_RUN  = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam int unsigned EMPTY_CELL = 0;

endpackage

// File: rtl/tron_headon_cmp.sv
// Pairwise position equality among live players; flags every player sharing a cell.
module tron_headon_cmp #(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned COORD_W     = 7
) (
    input  logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
    input  logic [NUM_PLAYERS-1:0]         alive,
    output logic [NUM_PLAYERS-1:0]         headon
);

    always_comb begin
        headon = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int q = 0; q < NUM_PLAYERS; q++) begin
                if (p != q && alive[p] && alive[q] &&
                    pos_x[p*COORD_W +: COORD_W] == pos_x[q*COORD_W +: COORD_W] &&
                    pos_y[p*COORD_W +: COORD_W] == pos_y[q*COORD_W +: COORD_W]) begin
                    headon[p] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tron_arbiter.sv
// Per-tick collision decider for N light cycles sharing one single-port arena map RAM.
module tron_arbiter
    import tron_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned COORD_W     = 7,
    parameter int unsigned CELL_W      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           game_start,
    input  logic                           tick,
    input  logic [NUM_PLAYERS*COORD_W-1:0] loc_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0] loc_y,
    output logic [2*COORD_W-1:0]           map_addr,
    output logic                           map_we,
    output logic [CELL_W-1:0]              map_wdata,
    input  logic [CELL_W-1:0]              map_rdata,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic [1:0]                     result,
    output logic [2:0]                     winner,
    output logic                           busy,
    output logic                           step_done,
    output logic                           tick_overrun
);

    localparam int unsigned AW = 2 * COORD_W;
    localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    state_e                         state_q, state_d;
    logic [AW-1:0]                  cnt_q, cnt_d;
    logic [NUM_PLAYERS*COORD_W-1:0] snap_x_q, snap_y_q;
    logic [NUM_PLAYERS-1:0]         alive_q, hit_q, headon, crash;
    logic [1:0]                     result_q;
    logic [2:0]                     winner_q, win_idx;
    logic                           running_q, step_done_q, overrun_q;
    logic                           rd_valid_q;
    logic [PW-1:0]                  rd_idx_q, pidx;
    logic [COORD_W-1:0]             cur_x, cur_y;
    logic [3:0]                     n_alive;
    logic                           accept_tick;

    assign pidx        = cnt_q[PW-1:0];
    assign cur_x       = snap_x_q[pidx*COORD_W +: COORD_W];
    assign cur_y       = snap_y_q[pidx*COORD_W +: COORD_W];
    assign accept_tick = tick && running_q && (state_q == StIdle);

    tron_headon_cmp #(
        .NUM_PLAYERS(NUM_PLAYERS),
        .COORD_W    (COORD_W)
    ) u_headon (
        .pos_x (snap_x_q),
        .pos_y (snap_y_q),
        .alive (alive_q),
        .headon(headon)
    );

    assign crash = alive_q & (hit_q | headon);

    always_comb begin
        n_alive = '0;
        win_idx = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (alive_q[p]) begin
                n_alive = n_alive + 4'd1;
                win_idx = 3'(p);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        map_addr  = '0;
        map_we    = 1'b0;
        map_wdata = '0;
        case (state_q)
            StIdle: begin
                if (accept_tick) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                map_addr = cnt_q;
                map_we   = 1'b1;
                if (cnt_q == '1) state_d = StIdle;
                else             cnt_d   = cnt_q + 1'b1;
            end
            StRead: begin
                map_addr = {cur_y, cur_x};
                if (cnt_q == AW'(NUM_PLAYERS - 1)) state_d = StCapture;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            StCapture: state_d = StCheck;
            StCheck: begin
                state_d = StWrite;
                cnt_d   = '0;
            end
            StWrite: begin
                map_addr  = {cur_y, cur_x};
                map_we    = alive_q[pidx];
                map_wdata = CELL_W'(pidx) + CELL_W'(1);
                if (cnt_q == AW'(NUM_PLAYERS - 1)) state_d = StResult;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            StResult: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (game_start) begin
            state_d = StClear;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            alive_q     <= '0;
            hit_q       <= '0;
            result_q    <= RES_RUN;
            winner_q    <= '0;
            running_q   <= 1'b0;
            step_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_done_q <= 1'b0;
            // Read data lags the address by one cycle; remember which player it belongs to.
            rd_valid_q  <= (state_q == StRead);
            rd_idx_q    <= pidx;
            if (rd_valid_q) hit_q[rd_idx_q] <= (map_rdata != CELL_W'(EMPTY_CELL));
            if (tick && !game_start && !accept_tick) overrun_q <= 1'b1;
            if (game_start) begin
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept_tick) begin
                            snap_x_q <= loc_x;
                            snap_y_q <= loc_y;
                        end
                    end
                    StClear: begin
                        if (cnt_q == '1) begin
                            alive_q   <= '1;
                            result_q  <= RES_RUN;
                            winner_q  <= '0;
                            overrun_q <= 1'b0;
                            running_q <= 1'b1;
                        end
                    end
                    StCheck: alive_q <= alive_q & ~crash;
                    StResult: begin
                        step_done_q <= 1'b1;
                        if (n_alive == 4'd0) begin
                            result_q  <= RES_DRAW;
                            winner_q  <= '0;
                            running_q <= 1'b0;
                        end else if (n_alive == 4'd1) begin
                            result_q  <= RES_WIN;
                            winner_q  <= win_idx;
                            running_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign alive        = alive_q;
    assign result       = result_q;
    assign winner       = winner_q;
    assign busy         = (state_q != StIdle);
    assign step_done    = step_done_q;
    assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_tron_arbiter.sv
// Directed bench for tron_arbiter with a behavioural single-port map RAM (COORD_W=3).
module tb_tron_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned CL = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            game_start = 1'b0;
    logic            tick = 1'b0;
    logic [NP*CW-1:0] loc_x = '0;
    logic [NP*CW-1:0] loc_y = '0;
    logic [2*CW-1:0] map_addr;
    logic            map_we;
    logic [CL-1:0]   map_wdata;
    logic [CL-1:0]   map_rdata;
    logic [NP-1:0]   alive;
    logic [1:0]      result;
    logic [2:0]      winner;
    logic            busy;
    logic            step_done;
    logic            tick_overrun;

    logic            pre_we = 1'b0;
    logic [2*CW-1:0] pre_addr = '0;
    logic [CL-1:0]   pre_data = '0;
    logic [CL-1:0]   mem [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tron_arbiter #(
        .NUM_PLAYERS(NP),
        .COORD_W    (CW),
        .CELL_W     (CL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .game_start  (game_start),
        .tick        (tick),
        .loc_x       (loc_x),
        .loc_y       (loc_y),
        .map_addr    (map_addr),
        .map_we      (map_we),
        .map_wdata   (map_wdata),
        .map_rdata   (map_rdata),
        .alive       (alive),
        .result      (result),
        .winner      (winner),
        .busy        (busy),
        .step_done   (step_done),
        .tick_overrun(tick_overrun)
    );

    always @(posedge clk) begin
        if (map_we)      mem[map_addr] <= map_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        map_rdata <= mem[map_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NP*CW-1:0] pk(input int a, input int b, input int c, input int d);
        pk = {CW'(d), CW'(c), CW'(b), CW'(a)};
    endfunction

    task automatic preload(input int x, input int y, input int v);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = {CW'(y), CW'(x)};
        pre_data = CL'(v);
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            check_eq($sformatf("%s_clr%0d", tag, i), {map_we, map_addr, map_wdata},
                     {1'b1, 6'(i), 4'h0});
        end
        @(negedge clk);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_alive"}, alive, 4'b1111);
        check_eq({tag, "_result"}, result, 0);
    endtask

    // Tick sampled at edge E0; reads at E0..E3, writes at E6..E9, step_done after E11.
    task automatic do_step(input string tag, input logic [NP*CW-1:0] lx,
                           input logic [NP*CW-1:0] ly, input logic [NP-1:0] exp_we);
        logic [5:0] a;
        @(negedge clk);
        loc_x = lx;
        loc_y = ly;
        tick  = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 0) begin
                tick  = 1'b0;
                loc_x = ~lx;
                loc_y = ~ly;
            end
            if (c <= 3) begin
                a = {ly[c*CW +: CW], lx[c*CW +: CW]};
                check_eq($sformatf("%s_rd%0d", tag, c), {map_we, map_addr}, {1'b0, a});
            end else if (c >= 6 && c <= 9) begin
                a = {ly[(c-6)*CW +: CW], lx[(c-6)*CW +: CW]};
                if (exp_we[c-6])
                    check_eq($sformatf("%s_wr%0d", tag, c - 6), {map_we, map_addr, map_wdata},
                             {1'b1, a, 4'(c - 5)});
                else
                    check_eq($sformatf("%s_nowr%0d", tag, c - 6), map_we, 0);
            end else if (c == 10) begin
                check_eq({tag, "_done_early"}, step_done, 0);
            end else if (c == 11) begin
                check_eq({tag, "_done"}, step_done, 1);
                check_eq({tag, "_busy_end"}, busy, 0);
            end
        end
    endtask

    initial begin
        #2;
        check_eq("rst_alive", alive, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_winner", winner, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_we", map_we, 0);
        check_eq("rst_addr", map_addr, 0);
        check_eq("rst_done", step_done, 0);
        check_eq("rst_ovr", tick_overrun, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Tick before any game has been armed.
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_eq("pre_game_ovr", tick_overrun, 1);
        check_eq("pre_game_busy", busy, 0);

        do_clear("c1");
        check_eq("c1_ovr_cleared", tick_overrun, 0);
        do_step("norm", pk(1, 5, 1, 5), pk(1, 1, 5, 5), 4'b1111);
        check_eq("norm_alive", alive, 4'b1111);
        check_eq("norm_result", result, 0);

        do_clear("c2");
        preload(5, 1, 1);
        do_step("trail", pk(1, 5, 1, 5), pk(1, 1, 5, 5), 4'b1101);
        check_eq("trail_alive", alive, 4'b1101);
        check_eq("trail_result", result, 0);

        do_clear("c3");
        do_step("kill13", pk(0, 6, 7, 6), pk(0, 6, 0, 6), 4'b0101);
        check_eq("kill13_alive", alive, 4'b0101);
        check_eq("kill13_result", result, 0);
        do_step("headon", pk(3, 6, 3, 6), pk(3, 6, 3, 6), 4'b0000);
        check_eq("headon_alive", alive, 0);
        check_eq("headon_result", result, 2'b11);
        check_eq("headon_winner", winner, 0);

        do_clear("c4");
        do_step("kill23", pk(0, 1, 7, 7), pk(1, 0, 7, 7), 4'b0011);
        check_eq("kill23_alive", alive, 4'b0011);
        do_step("last", pk(1, 2, 0, 0), pk(0, 0, 0, 0), 4'b0010);
        check_eq("last_alive", alive, 4'b0010);
        check_eq("last_result", result, 2'b01);
        check_eq("last_winner", winner, 1);
        check_eq("last_ovr_before", tick_overrun, 0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_eq("last_ignored_busy", busy, 0);
        check_eq("last_ovr", tick_overrun, 1);
        check_eq("last_result_hold", result, 2'b01);
        check_eq("last_winner_hold", winner, 1);

        // Abort during WRITE.
        do_clear("c5");
        @(negedge clk);
        loc_x = pk(1, 5, 1, 5);
        loc_y = pk(1, 1, 5, 5);
        tick  = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            tick = 1'b0;
        end
        check_eq("abort_in_write", map_we, 1);
        game_start = 1'b1;
        @(negedge clk);
        game_start = 1'b0;
        check_eq("abort_clear0", {busy, map_we, map_addr, map_wdata}, {2'b11, 6'd0, 4'h0});
        repeat (64) @(negedge clk);
        check_eq("abort_idle", busy, 0);
        check_eq("abort_alive", alive, 4'b1111);

        // Asynchronous reset mid-READ.
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        check_eq("rr_busy_pre", busy, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("rr_alive", alive, 0);
        check_eq("rr_busy", busy, 0);
        check_eq("rr_we_addr", {map_we, map_addr}, 0);
        check_eq("rr_res_win", {result, winner}, 0);
        check_eq("rr_done_ovr", {step_done, tick_overrun}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rr_after_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tron_arbiter.md
Name: tron_arbiter

Overview:
N-player successor to the two-player collision decider for the Tron light-cycle game.
- On each game tick it snapshots all player positions and reads the shared arena map through one external single-port map RAM.
- It detects trail crashes and head-on collisions, writes surviving players' trail cells, and reports alive mask, result and winner to the PicoBlaze side.
- It also clears the arena at game start. Display selection stays in the existing video path.

Parameters:
NUM_PLAYERS, 4, number of players (2..8)
COORD_W, 7, bits per X/Y coordinate; map address = {y,x}, width 2*COORD_W
CELL_W, 4, map cell width; 0 = empty, player p owns value p+1 (requires 2**CELL_W > NUM_PLAYERS)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
game_start  in  1  one-cycle pulse: clear arena, arm new game
tick  in  1  one-cycle pulse: new positions valid on loc_x/loc_y
loc_x  in  NUM_PLAYERS*COORD_W  packed X positions, player 0 in LSBs
loc_y  in  NUM_PLAYERS*COORD_W  packed Y positions, player 0 in LSBs
map_addr  out  2*COORD_W  map RAM address {y,x}
map_we  out  1  map RAM write enable
map_wdata  out  CELL_W  map RAM write data
map_rdata  in  CELL_W  map RAM read data, valid one cycle after address
alive  out  NUM_PLAYERS  bit p set while player p survives
result  out  2  00 running/idle, 01 single winner, 11 draw
winner  out  3  index of winning player when result=01, else 0
busy  out  1  high in every state except IDLE
step_done  out  1  one-cycle pulse when a tick has been fully processed
tick_overrun  out  1  sticky; set when tick arrives while busy or while not running

Behaviour:
- Clock is clk, single domain. Reset is asynchronous and active-high, named reset.
- Reset values: every output is 0, the running flag is 0, and the state is IDLE.
- States:
  - IDLE
  - CLEAR
  - READ: NUM_PLAYERS cycles.
  - CAPTURE: 1 cycle.
  - CHECK: 1 cycle.
  - WRITE: NUM_PLAYERS cycles.
  - RESULT: 1 cycle.
- game_start, any state: go to CLEAR. It aborts any step in progress and takes priority over a tick in the same cycle.
- CLEAR:
  - Writes 0 to addresses 0..2**(2*COORD_W)-1, one per cycle, ascending, with map_we=1.
  - On the last address: alive = all ones, result = 00, winner = 0, tick_overrun = 0, running = 1, go to IDLE.
- IDLE with tick and running:
  - Snapshot loc_x/loc_y into internal registers and go to READ.
  - Later input changes have no effect on this step.
- tick when not running, or in any non-IDLE state: ignored; set tick_overrun.
- READ:
  - Cycle k drives map_addr = snapshot position of player k, map_we = 0.
  - map_rdata is captured one cycle later into hit[k] = (map_rdata != 0). Dead players are still addressed, but their hit bit is ignored.
- CAPTURE: receives the final read data.
- CHECK:
  - crash[p] = alive[p] & (hit[p] | any q != p with alive[q] and equal {x,y}).
  - alive <= alive & ~crash.
- WRITE:
  - Cycle k writes value k+1 at player k's snapshot position, only if player k is still alive.
  - Otherwise map_we = 0 in that cycle.
  - The cycle count is fixed regardless of survivors.
- RESULT, based on the surviving count:
  - 0: result = 11, winner = 0, running = 0.
  - 1: result = 01, winner = index of the survivor, running = 0.
  - 2 or more: result stays 00.
  - In all cases step_done = 1 for this cycle, then go to IDLE.
- Latency: RESULT (and step_done) occurs 2*NUM_PLAYERS+3 edges after the edge that samples tick; 11 for the default.
- Once result != 00, it and winner hold until game_start or reset.
- Map values outside 1..NUM_PLAYERS are treated as obstacles (nonzero = hit).
- Position wrap-around is the producer's job; no bounds checking here.
- Reset mid-CLEAR or mid-WRITE: the map is left partially written; game_start is required before play.

Decomposition:
- Shared package tron_pkg holds:
  - state enum,
  - result codes RES_RUN=2'b00, RES_WIN=2'b01, RES_DRAW=2'b11,
  - EMPTY_CELL=0.
- One sub-module: tron_headon_cmp, a combinational pairwise equality matrix.
  - Inputs: the snapshot positions and the alive mask.
  - Output: a per-player head-on bitmask.

Test Plan:
- Clear sweep: COORD_W=3, game_start -> 64 consecutive writes of 0 at addresses 0..63, then alive=4'b1111, busy=0.
- Normal step: players at (1,1),(5,1),(1,5),(5,5) on an empty map, tick -> writes 1,2,3,4 at addresses {1,1},{1,5},{5,1},{5,5}; step_done exactly 11 cycles after tick; result=00.
- Trail crash: preload (5,1)=1, player 1 moves there -> alive=4'b1101; player 1's cell not written; result=00.
- Head-on: players 0 and 2 both at (3,3), players 1 and 3 dead -> alive=0, result=11, winner=0.
- Last survivor: players 0,1 alive, player 0 hits a trail -> result=01, winner=1; a following tick is ignored and sets tick_overrun=1.
- Abort/reset: game_start during WRITE -> CLEAR starts next cycle; async reset mid-READ -> all outputs 0 immediately, without waiting for a clock edge.
